pengo_dl_ctrl: RTL and testbench



---
 rtl/pengo_dl_pkg.sv | 12 +
 rtl/pengo_dl_decode.sv | 21 ++
 rtl/pengo_dl_ctrl.sv | 87 ++++++++
 tb/tb_pengo_dl_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pengo_dl_pkg.sv
// pengo_dl_pkg: shared region map, region encodings and controller states
package pengo_dl_pkg;
  localparam logic [15:0] CPU_BASE   = 16'h0000;
  localparam logic [15:0] GFX_BASE   = 16'h8000;
  localparam logic [15:0] PROM_BASE  = 16'hC000;
  localparam logic [15:0] PROM_LIMIT = 16'hC21F;
  localparam logic [2:0] REG_NONE = 3'b000;
  localparam logic [2:0] REG_CPU  = 3'b001;
  localparam logic [2:0] REG_GFX  = 3'b010;
  localparam logic [2:0] REG_PROM = 3'b100;
  typedef enum logic [1:0] {SETTLE, WAIT, LOAD, RUN} state_t;
endpackage

// File: rtl/pengo_dl_decode.sv
// pengo_dl_decode: linear download address to region strobe and region-relative address
module pengo_dl_decode
  import pengo_dl_pkg::*;
(
  input  logic [24:0] addr,
  output logic        valid,
  output logic [2:0]  region,
  output logic [15:0] rel_addr
);
  logic [15:0] a;
  logic        hi;
  assign a  = addr[15:0];
  assign hi = |addr[24:16];
  // region by ascending base; anything above the PROM tail or above 64K is out of range
  always_comb begin
    region   = hi ? REG_NONE : a < GFX_BASE ? REG_CPU : a < PROM_BASE ? REG_GFX :
               a <= PROM_LIMIT ? REG_PROM : REG_NONE;
    rel_addr = region == REG_GFX ? a - GFX_BASE : region == REG_PROM ? a - PROM_BASE : a - CPU_BASE;
    valid    = |region;
  end
endmodule

// File: rtl/pengo_dl_ctrl.sv
// pengo_dl_ctrl: ROM download sequencer holding the pengo core in reset until a valid image settles
module pengo_dl_ctrl
  import pengo_dl_pkg::*;
#(
  parameter int          REL_DELAY = 1024,
  parameter logic [16:0] IMG_SIZE  = 17'hC220
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        ext_reset,
  output logic        core_reset,
  output logic        rom_wr,
  output logic [2:0]  rom_region,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [16:0] byte_count,
  output logic        dl_done,
  output logic        dl_err
);
  localparam int CW = $clog2(REL_DELAY + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          err_pend, dec_valid, acc, good, err_n, load_ok;
  logic [2:0]    dec_region;
  logic [15:0]   dec_rel;
  logic [16:0]   bc_n;
  pengo_dl_decode u_decode (
    .addr    (dl_addr),
    .valid   (dec_valid),
    .region  (dec_region),
    .rel_addr(dec_rel)
  );
  assign acc        = dl_wr & (dl_active | state == LOAD);
  assign good       = acc & dec_valid;
  assign core_reset = state == RUN ? ext_reset : 1'b1;
  // in-load count/error after this cycle's write, also used for the end-of-load verdict
  always_comb begin
    bc_n    = good && byte_count != 17'h1FFFF ? byte_count + 17'd1 : byte_count;
    err_n   = err_pend | (acc & ~dec_valid);
    load_ok = bc_n == IMG_SIZE && !err_n;
  end
  // download FSM plus registered write port; the entry cycle of a load already accepts a write
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      cnt        <= '0;
      rom_wr     <= 1'b0;
      rom_region <= REG_NONE;
      rom_addr   <= '0;
      rom_data   <= '0;
      byte_count <= '0;
      dl_done    <= 1'b0;
      dl_err     <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      rom_wr <= good;
      if (good) begin
        rom_region <= dec_region;
        rom_addr   <= dec_rel;
        rom_data   <= dl_data;
      end
      if (state != LOAD && dl_active) begin
        state      <= LOAD;
        byte_count <= {16'd0, good};
        err_pend   <= acc & ~dec_valid;
        dl_done    <= 1'b0;
        dl_err     <= 1'b0;
      end else if (state == LOAD) begin
        byte_count <= bc_n;
        err_pend   <= err_n;
        if (!dl_active) begin
          state   <= SETTLE;
          cnt     <= '0;
          dl_done <= load_ok;
          dl_err  <= !load_ok;
        end
      end else if (state == SETTLE) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(REL_DELAY - 1)) state <= dl_done ? RUN : WAIT;
      end
    end
  end
endmodule

// File: tb/tb_pengo_dl_ctrl.sv
// tb_pengo_dl_ctrl: randomized self-checking bench; a full-size instance plus a small-image instance share all inputs
module tb_pengo_dl_ctrl;
  logic        clk = 1'b0;
  logic        reset, dl_active, dl_wr, ext_reset;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        core_reset, rom_wr, dl_done, dl_err;
  logic [2:0]  rom_region;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [16:0] byte_count;
  logic        s_core_reset, s_rom_wr, s_dl_done, s_dl_err;
  logic [2:0]  s_rom_region;
  logic [15:0] s_rom_addr;
  logic [7:0]  s_rom_data;
  logic [16:0] s_byte_count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pengo_dl_ctrl dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .ext_reset(ext_reset), .core_reset(core_reset), .rom_wr(rom_wr),
    .rom_region(rom_region), .rom_addr(rom_addr), .rom_data(rom_data),
    .byte_count(byte_count), .dl_done(dl_done), .dl_err(dl_err)
  );

  pengo_dl_ctrl #(.REL_DELAY(1024), .IMG_SIZE(17'h0100)) dut_s (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .ext_reset(ext_reset), .core_reset(s_core_reset), .rom_wr(s_rom_wr),
    .rom_region(s_rom_region), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .byte_count(s_byte_count), .dl_done(s_dl_done), .dl_err(s_dl_err)
  );

  // reference memory map: region one-hot (0 = out of range) and offset from the region start
  function automatic void ref_map(input int unsigned a, output logic [2:0] r, output logic [15:0] rel);
    r = 3'b000;
    rel = 16'h0000;
    if (a < 32'h8000) begin r = 3'b001; rel = 16'(a); end
    else if (a < 32'hC000) begin r = 3'b010; rel = 16'(a - 32'h8000); end
    else if (a < 32'hC220) begin r = 3'b100; rel = 16'(a - 32'hC000); end
  endfunction

  // present one download byte; returns at the next falling edge where its result is visible
  task automatic write_byte(input int unsigned a, input logic [7:0] d);
    dl_active = 1'b1;
    dl_wr = 1'b1;
    dl_addr = 25'(a);
    dl_data = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; ext_reset = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({core_reset, rom_wr, rom_region, rom_addr, rom_data, byte_count, dl_done, dl_err,
         s_core_reset, s_rom_wr, s_byte_count, s_dl_done, s_dl_err} !==
        {1'b1, 1'b0, 3'b0, 16'h0, 8'h0, 17'h0, 1'b0, 1'b0, 1'b1, 1'b0, 17'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got core_reset=%b rom_wr=%b region=%b addr=%h data=%h count=%h done=%b err=%b, want 1 0 000 0000 00 00000 0 0",
               core_reset, rom_wr, rom_region, rom_addr, rom_data, byte_count, dl_done, dl_err);
    end
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      total++;
      if (core_reset !== 1'b1 || dl_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: core_reset=%b dl_done=%b, want 1 0", i, core_reset, dl_done);
      end
    end
  endtask

  task automatic test_full_load;
    logic [2:0] r;
    logic [15:0] rel;
    for (int unsigned a = 0; a < 32'hC220; a++) begin
      write_byte(a, 8'(a));
      ref_map(a, r, rel);
      total++;
      if ({rom_wr, rom_region, rom_addr, rom_data} !== {1'b1, r, rel, 8'(a)}) begin
        bad++;
        $display("FAIL full_write %h: got wr=%b region=%b addr=%h data=%h, want 1 %b %h %h",
                 a, rom_wr, rom_region, rom_addr, rom_data, r, rel, 8'(a));
      end
      if (a == 32'h8005 || a == 32'hC120) begin
        total++;
        if (rom_region !== (a == 32'h8005 ? 3'b010 : 3'b100) || rom_addr !== (a == 32'h8005 ? 16'h0005 : 16'h0120)) begin
          bad++;
          $display("FAIL map_point %h: got region=%b addr=%h", a, rom_region, rom_addr);
        end
      end
    end
    dl_active = 1'b0;
    dl_wr = 1'b0;
    @(negedge clk);
    total++;
    if ({rom_wr, byte_count, dl_done, dl_err, core_reset} !== {1'b0, 17'hC220, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL full_status: got wr=%b count=%h done=%b err=%b core_reset=%b, want 0 0c220 1 0 1",
               rom_wr, byte_count, dl_done, dl_err, core_reset);
    end
    for (int i = 1; i < 1024; i++) begin
      @(negedge clk);
      total++;
      if (core_reset !== 1'b1) begin
        bad++;
        $display("FAIL full_settle edge %0d: core_reset=%b, want 1", i + 1, core_reset);
      end
    end
    @(negedge clk);
    total++;
    if (core_reset !== 1'b0) begin
      bad++;
      $display("FAIL full_release: core_reset=%b, want 0", core_reset);
    end
  endtask

  task automatic test_run_ext;
    int start, highs;
    logic want;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      dl_active = 1'b0;
      dl_wr = 1'b1;
      dl_addr = 25'($urandom_range(0, 32'hC21F));
      dl_data = 8'($urandom);
      @(negedge clk);
      total++;
      if ({rom_wr, byte_count, dl_done, core_reset} !== {1'b0, 17'hC220, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL run_drop %0d: got wr=%b count=%h done=%b core_reset=%b, want 0 0c220 1 0",
                 k, rom_wr, byte_count, dl_done, core_reset);
      end
    end
    dl_wr = 1'b0;
    start = $urandom_range(2, 5);
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      want = c >= start && c < start + 3;
      ext_reset = want;
      #1;
      total++;
      if (core_reset !== want) begin
        bad++;
        $display("FAIL ext_pass cycle %0d: core_reset=%b, want %b", c, core_reset, want);
      end
      highs += int'(core_reset === 1'b1);
      @(negedge clk);
    end
    ext_reset = 1'b0;
    total++;
    if (highs != 3) begin
      bad++;
      $display("FAIL ext_width: high cycles=%0d, want 3", highs);
    end
  endtask

  // stream a byte list into the small instance, checking each registered write and held outputs
  task automatic load_small(input string name, input int unsigned addrs[$]);
    logic [2:0] r, lr;
    logic [15:0] rel, lrel;
    logic [7:0] d, ld;
    lr = 3'b000; lrel = 16'h0; ld = 8'h0;
    foreach (addrs[i]) begin
      d = 8'($urandom);
      write_byte(addrs[i], d);
      ref_map(addrs[i], r, rel);
      if (r != 3'b000) begin lr = r; lrel = rel; ld = d; end
      total++;
      if ({s_rom_wr, s_rom_region, s_rom_addr, s_rom_data} !== {r != 3'b000, lr, lrel, ld}) begin
        bad++;
        $display("FAIL %s write %h: got wr=%b region=%b addr=%h data=%h, want %b %b %h %h",
                 name, addrs[i], s_rom_wr, s_rom_region, s_rom_addr, s_rom_data, r != 3'b000, lr, lrel, ld);
      end
    end
    dl_active = 1'b0;
    dl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_held(input string name);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      total++;
      if (s_core_reset !== 1'b1) begin
        bad++;
        $display("FAIL %s held cycle %0d: core_reset=%b, want 1", name, i, s_core_reset);
      end
    end
  endtask

  task automatic test_out_of_range;
    int unsigned q[$];
    int p1, p2;
    p1 = $urandom_range(0, 255);
    p2 = $urandom_range(0, 255);
    for (int i = 0; i < 256; i++) begin
      q.push_back(i);
      if (i == p1) q.push_back(32'hC220);
      if (i == p2) q.push_back(32'h10000);
    end
    load_small("oor", q);
    total++;
    if ({s_byte_count, s_dl_done, s_dl_err} !== {17'h0100, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL oor_status: got count=%h done=%b err=%b, want 00100 0 1", s_byte_count, s_dl_done, s_dl_err);
    end
    expect_held("oor");
  endtask

  task automatic test_short;
    int unsigned q[$];
    for (int i = 0; i < 128; i++) q.push_back($urandom_range(0, 32'hC21F));
    load_small("short", q);
    total++;
    if ({s_byte_count, s_dl_done, s_dl_err} !== {17'h0080, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL short_status: got count=%h done=%b err=%b, want 00080 0 1", s_byte_count, s_dl_done, s_dl_err);
    end
    expect_held("short");
  endtask

  task automatic test_reset_mid;
    int unsigned q[$];
    for (int unsigned a = 32'h3F00; a < 32'h4000; a++) q.push_back(a);
    foreach (q[i]) write_byte(q[i], 8'($urandom));
    reset = 1'b1;
    write_byte(32'h4000, 8'hA5);
    total++;
    if ({rom_wr, byte_count, dl_done, core_reset, s_rom_wr, s_byte_count, s_dl_done, s_core_reset} !==
        {1'b0, 17'h0, 1'b0, 1'b1, 1'b0, 17'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset: got wr=%b count=%h done=%b core_reset=%b small wr=%b count=%h, want 0 00000 0 1 / 0 00000",
               rom_wr, byte_count, dl_done, core_reset, s_rom_wr, s_byte_count);
    end
    reset = 1'b0;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    expect_held("mid");
    q.delete();
    for (int unsigned a = 0; a < 256; a++) q.push_back(a);
    load_small("reload", q);
    total++;
    if ({s_byte_count, s_dl_done, s_dl_err} !== {17'h0100, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reload_status: got count=%h done=%b err=%b, want 00100 1 0", s_byte_count, s_dl_done, s_dl_err);
    end
    repeat (1023) @(negedge clk);
    total++;
    if (s_core_reset !== 1'b1) begin
      bad++;
      $display("FAIL reload_settle: core_reset=%b one edge before release, want 1", s_core_reset);
    end
    @(negedge clk);
    total++;
    if (s_core_reset !== 1'b0) begin
      bad++;
      $display("FAIL reload_release: core_reset=%b, want 0", s_core_reset);
    end
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_run_ext;
    test_out_of_range;
    test_short;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
